// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared port arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_resp_valid;
  logic [31:0] if_rdata;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_resp_valid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_addr, d_be, d_wdata,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output d_req_ready, d_resp_valid, d_rdata,
    output mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_addr, d_be, d_wdata,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  d_req_ready, d_resp_valid, d_rdata,
    input  mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, with data
// priority, a fetch anti-starvation limit and a programmable access latency.
//
//   state  | meaning
//   IDLE   | port free, arbitrating between requesters
//   ACCESS | port owned by the latched requester, counting MEM_LAT cycles
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        owner_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q, lat_cnt_q, starve_cnt_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        if_resp_q, d_resp_q;
  logic        fetch_win, data_win, contested, last_beat;

  // Grants only exist in IDLE and never while reset is held.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.if_req_valid && (!bus.d_req_valid || starve_cnt_q == STARVE_LIM))
        fetch_win = 1'b1;
      else if (bus.d_req_valid)
        data_win = 1'b1;
    end
  end

  assign contested = bus.if_req_valid && bus.d_req_valid;
  assign last_beat = (state_q == ACCESS) && (lat_cnt_q == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_win || data_win) state_d = ACCESS;
      ACCESS:  if (last_beat)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte enables only on the first ACCESS cycle so a store writes exactly once.
  always_comb begin
    bus.if_req_ready = fetch_win;
    bus.d_req_ready  = data_win;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_be       = '0;
    if (state_q == ACCESS && !rst) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      if (lat_cnt_q == 4'd0) bus.mem_be = be_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_resp_q    <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      if_resp_q <= 1'b0;
      d_resp_q  <= 1'b0;
      if (fetch_win) begin
        owner_q      <= 1'b0;
        addr_q       <= bus.if_addr;
        be_q         <= 4'b0000;
        wdata_q      <= '0;
        lat_cnt_q    <= '0;
        starve_cnt_q <= '0;
      end else if (data_win) begin
        owner_q   <= 1'b1;
        addr_q    <= bus.d_addr;
        be_q      <= bus.d_be;
        wdata_q   <= bus.d_wdata;
        lat_cnt_q <= '0;
        if (contested && starve_cnt_q != STARVE_LIM)
          starve_cnt_q <= starve_cnt_q + 4'd1;
      end else if (state_q == ACCESS) begin
        lat_cnt_q <= lat_cnt_q + 4'd1;
        if (last_beat) begin
          if (owner_q) begin
            d_rdata_q <= bus.mem_rdata;
            d_resp_q  <= 1'b1;
          end else begin
            if_rdata_q <= bus.mem_rdata;
            if_resp_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.if_rdata      = if_rdata_q;
  assign bus.if_resp_valid = if_resp_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.d_resp_valid  = d_resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut1 runs MEM_LAT=1, dut2 runs MEM_LAT=2, both STARVE_MAX=4,
// each with its own word-addressed memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  int   tests = 0;
  int   fails = 0;

  mem_port_arbiter_if b1();
  mem_port_arbiter_if b2();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut2 (.clk(clk), .rst(rst2), .bus(b2.slave));

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];

  assign b1.mem_rdata = mem1[b1.mem_addr[9:2]];
  assign b2.mem_rdata = mem2[b2.mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = '0;
    mem1[0] = 32'h00500093;
    mem1[1] = 32'h00A00113;
    forever begin
      @(posedge clk);
      for (int l = 0; l < 4; l++)
        if (b1.mem_be[l]) mem1[b1.mem_addr[9:2]][8*l +: 8] <= b1.mem_wdata[8*l +: 8];
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem2[i] = '0;
    mem2[0]    = 32'h00500093;
    mem2[1]    = 32'h00A00113;
    mem2[2]    = 32'hCAFEF00D;
    mem2[8'h41] = 32'h11223344;
    mem2[8'h80] = 32'h0BADF00D;
    forever begin
      @(posedge clk);
      for (int l = 0; l < 4; l++)
        if (b2.mem_be[l]) mem2[b2.mem_addr[9:2]][8*l +: 8] <= b2.mem_wdata[8*l +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // One transaction on dut2: drive, handshake, then watch until the owner's response.
  task automatic run_txn(input vec_t v, output logic acc, output logic [31:0] rdata,
                         output int lat, output int be_cycles, output logic [31:0] seen_addr,
                         output logic [31:0] other_before, output logic [31:0] other_after,
                         output int other_resp);
    @(negedge clk);
    other_before = v.is_d ? b2.if_rdata : b2.d_rdata;
    if (v.is_d) begin
      b2.d_req_valid = 1'b1; b2.d_addr = v.addr; b2.d_be = v.be; b2.d_wdata = v.wdata;
    end else begin
      b2.if_req_valid = 1'b1; b2.if_addr = v.addr;
    end
    #1 acc = v.is_d ? b2.d_req_ready : b2.if_req_ready;
    @(posedge clk);
    #1 b2.d_req_valid = 1'b0; b2.if_req_valid = 1'b0;
    lat = -1; be_cycles = 0; seen_addr = '0; other_resp = 0; rdata = '0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (b2.mem_be != 4'b0000) be_cycles++;
      if (c == 1) seen_addr = b2.mem_addr;
      if (v.is_d ? b2.if_resp_valid : b2.d_resp_valid) other_resp++;
      if (v.is_d ? b2.d_resp_valid : b2.if_resp_valid) begin
        lat   = c;
        rdata = v.is_d ? b2.d_rdata : b2.if_rdata;
      end
    end
    other_after = v.is_d ? b2.if_rdata : b2.d_rdata;
  endtask

  initial begin
    logic        acc;
    logic [31:0] rdata, seen_addr, ob, oa;
    int          lat, bec, oresp, ng, cnt;
    bit          grants [10];
    bit          exp_g  [10];
    vec_t        v;

    vecs[0] = '{1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h104, 4'b0001, 32'h000000AA, 32'h0};
    vecs[3] = '{1'b1, 32'h104, 4'b0000, 32'h0,        32'h112233AA};
    vecs[4] = '{1'b1, 32'h108, 4'b1100, 32'h55665566, 32'h0};
    vecs[5] = '{1'b1, 32'h108, 4'b0000, 32'h0,        32'h55660000};
    vecs[6] = '{1'b0, 32'h000, 4'b0000, 32'h0,        32'h00500093};
    vecs[7] = '{1'b0, 32'h102, 4'b0000, 32'h0,        32'hDEADBEEF};
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst1 = 1'b1; rst2 = 1'b1;
    b1.if_req_valid = 1'b0; b1.if_addr = '0; b1.d_req_valid = 1'b0;
    b1.d_addr = '0; b1.d_be = '0; b1.d_wdata = '0;
    b2.if_req_valid = 1'b0; b2.if_addr = '0; b2.d_req_valid = 1'b0;
    b2.d_addr = '0; b2.d_be = '0; b2.d_wdata = '0;

    // Reset state, with both requests asserted to prove readies are held low.
    repeat (2) @(negedge clk);
    b1.if_req_valid = 1'b1; b1.d_req_valid = 1'b1;
    #1;
    chk("rst if_ready", b1.if_req_ready, 0);
    chk("rst d_ready",  b1.d_req_ready, 0);
    chk("rst if_rdata", b1.if_rdata, 0);
    chk("rst d_rdata",  b1.d_rdata, 0);
    chk("rst resp",     {b1.if_resp_valid, b1.d_resp_valid}, 0);
    chk("rst mem_be",   b1.mem_be, 0);
    b1.if_req_valid = 1'b0; b1.d_req_valid = 1'b0;
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;

    // Single fetch, MEM_LAT=1.
    @(negedge clk);
    b1.if_req_valid = 1'b1; b1.if_addr = 32'h0;
    #1 chk("t1 c0 if_ready", b1.if_req_ready, 1);
    @(posedge clk); #1 b1.if_req_valid = 1'b0;
    @(negedge clk);
    chk("t1 c1 mem_addr", b1.mem_addr, 0);
    chk("t1 c1 mem_be",   b1.mem_be, 0);
    chk("t1 c1 resp",     b1.if_resp_valid, 0);
    @(negedge clk);
    chk("t1 c2 resp",     b1.if_resp_valid, 1);
    chk("t1 c2 rdata",    b1.if_rdata, 32'h00500093);
    @(negedge clk);
    chk("t1 c3 resp",     b1.if_resp_valid, 0);

    // Back-to-back fetches, valid held high.
    @(negedge clk);
    b1.if_addr = 32'h4; b1.if_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t4 c%0d ready", k), b1.if_req_ready, 32'((k % 2) == 0));
      chk($sformatf("t4 c%0d resp", k),  b1.if_resp_valid, 32'((k % 2) == 0 && k > 0));
      if (k == 7) b1.if_req_valid = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("t4 last resp",  b1.if_resp_valid, 1);
    chk("t4 last rdata", b1.if_rdata, 32'h00A00113);

    // Contention: both valid continuously.
    @(negedge clk);
    b1.if_req_valid = 1'b1; b1.if_addr = 32'h0;
    b1.d_req_valid = 1'b1; b1.d_addr = 32'h100; b1.d_be = 4'b0000;
    ng = 0; cnt = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      #1;
      if (b1.if_req_ready && b1.d_req_ready) cnt++;
      if (b1.if_req_ready)     begin grants[ng] = 1'b0; ng++; end
      else if (b1.d_req_ready) begin grants[ng] = 1'b1; ng++; end
      @(negedge clk);
    end
    b1.if_req_valid = 1'b0; b1.d_req_valid = 1'b0;
    chk("t3 grant count", ng, 10);
    chk("t3 double ready", cnt, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t3 grant%0d (1=D)", i), 32'(grants[i]), 32'(exp_g[i]));
    repeat (3) @(negedge clk);

    // Table-driven single transactions on dut2 (MEM_LAT=2).
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], acc, rdata, lat, bec, seen_addr, ob, oa, oresp);
      chk($sformatf("vec%0d accept", i), acc, 1);
      chk($sformatf("vec%0d latency", i), lat, 3);
      if (!vecs[i].is_d || vecs[i].be == 4'b0000)
        chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d be cycles", i), bec, 32'(vecs[i].be != 4'b0000));
      chk($sformatf("vec%0d mem_addr", i), seen_addr, vecs[i].addr);
      chk($sformatf("vec%0d other rdata hold", i), oa, ob);
      chk($sformatf("vec%0d other resp", i), oresp, 0);
    end

    // Withdrawn fetch while a load owns the port.
    @(negedge clk);
    b2.d_req_valid = 1'b1; b2.d_addr = 32'h104; b2.d_be = 4'b0000;
    @(posedge clk);
    #1 b2.d_req_valid = 1'b0;
    b2.if_req_valid = 1'b1; b2.if_addr = 32'h8;
    @(negedge clk);
    chk("t6 if_ready in access", b2.if_req_ready, 0);
    @(posedge clk);
    #1 b2.if_req_valid = 1'b0;
    cnt = 0; oresp = 0; ng = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b2.if_resp_valid) cnt++;
      if (b2.if_req_ready) ng++;
      if (b2.d_resp_valid) oresp++;
    end
    chk("t6 if resp count", cnt, 0);
    chk("t6 if grant count", ng, 0);
    chk("t6 d resp count", oresp, 1);
    chk("t6 d rdata", b2.d_rdata, 32'h112233AA);
    chk("t6 if_rdata hold", b2.if_rdata, 32'hDEADBEEF);

    // Reset in the first ACCESS cycle of a store.
    @(negedge clk);
    b2.d_req_valid = 1'b1; b2.d_addr = 32'h200; b2.d_be = 4'b1111; b2.d_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    b2.d_req_valid = 1'b0;
    chk("t5 mem_be before rst", b2.mem_be, 4'b1111);
    rst2 = 1'b1;
    #1;
    chk("t5 mem_be in rst", b2.mem_be, 0);
    chk("t5 d_ready in rst", b2.d_req_ready, 0);
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (b2.d_resp_valid) cnt++;
    end
    rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (b2.d_resp_valid) cnt++;
    end
    chk("t5 d resp count", cnt, 0);
    chk("t5 mem unchanged", mem2[8'h80], 32'h0BADF00D);
    chk("t5 d_rdata cleared", b2.d_rdata, 0);
    v = '{1'b1, 32'h200, 4'b0000, 32'h0, 32'h0BADF00D};
    run_txn(v, acc, rdata, lat, bec, seen_addr, ob, oa, oresp);
    chk("t5 post accept", acc, 1);
    chk("t5 post latency", lat, 3);
    chk("t5 post rdata", rdata, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
